imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 153 +++++++++++++++
 tb/tb_imem_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader -- streams a little-endian byte sequence into instruction memory.
//
// A load session begins with start in IDLE, which latches the word count.
// Bytes are packed four at a time into a 32-bit word, which is then written to
// consecutive word-aligned addresses. The processor is held in reset for the
// whole session, and done pulses once the last word has been written.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to build a running 32-bit sum
// of the written words. Without it, checksum is tied to zero.
//
// Ports:
//   clk         in   clock; all state changes on its rising edge
//   reset       in   synchronous, active-low reset
//   start       in   begin a load session (honoured only in IDLE)
//   num_words   in   words to load (0 or >DEPTH means DEPTH), sampled on start
//   byte_valid  in   byte_data carries a byte
//   byte_data   in   program byte stream
//   byte_ready  out  loader accepts a byte this cycle
//   we          out  instruction-memory write enable
//   wa          out  instruction-memory byte address (word aligned)
//   wd          out  instruction-memory write data
//   cpu_hold    out  keeps the processor in reset during a session
//   done        out  one-cycle pulse at session end
//   checksum    out  sum of written words (0 unless IMEM_LOADER_CHECKSUM_EN)
//
// State | meaning
// IDLE  | waiting for start
// RECV  | accepting bytes of the current word
// WRITE | one-cycle memory write of the assembled word
// DONE  | one-cycle completion pulse
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  num_words,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic        cpu_hold,
  output logic        done,
  output logic [31:0] checksum
);

  localparam int IDX_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [31:0]        word_q, word_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic [IDX_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   count_start;

  // Zero and over-range requests both mean "fill the whole memory".
  always_comb begin
    if (num_words == 7'd0 || int'(num_words) > DEPTH) begin
      count_start = IDX_W'(DEPTH);
    end else begin
      count_start = IDX_W'(num_words);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_q     <= '0;
      word_idx_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      word_idx_q <= word_idx_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    word_idx_d = word_idx_q;
    count_d    = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          count_d    = count_start;
          byte_cnt_d = '0;
          word_idx_d = '0;
          word_d     = '0;
          state_d    = RECV;
        end
      end
      RECV: begin
        if (byte_valid) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = byte_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + 1'b1;
        if (word_idx_d == count_q) begin
          state_d = DONE;
        end else begin
          state_d = RECV;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign byte_ready = (state_q == RECV);
  assign we         = (state_q == WRITE);
  assign cpu_hold   = (state_q != IDLE);
  assign done       = (state_q == DONE);
  // Address and data are forced to zero outside the write cycle.
  assign wa         = we ? (32'(word_idx_q) << 2) : 32'd0;
  assign wd         = we ? word_q : 32'd0;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      checksum_q <= '0;
    end else if (state_q == IDLE && start) begin
      checksum_q <= '0;
    end else if (state_q == WRITE) begin
      checksum_q <= checksum_q + word_q;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  num_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        cpu_hold;
  logic        done;
  logic [31:0] checksum;

  imem_loader #(.DEPTH(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [31:0] wa;
    logic [31:0] wd;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] bytes_q[$];
  int         vectors = 0;
  int         errors  = 0;
  int         writes_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every write or done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (we === 1'b1) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_we", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("we_is_write", 32'(e.is_done), 32'd0);
          chk("wa", wa, e.wa);
          chk("wd", wd, e.wd);
          chk("ready_in_write", 32'(byte_ready), 32'd0);
          chk("hold_in_write", 32'(cpu_hold), 32'd1);
        end
      end
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_is_done", 32'(e.is_done), 32'd1);
          chk("checksum", checksum, e.wd);
          chk("hold_in_done", 32'(cpu_hold), 32'd1);
        end
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_wa", wa, 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_checksum", checksum, 32'd0);
  endtask

  // Runs one session using bytes_q. abort_after < 0: complete session;
  // otherwise reset is applied once that many bytes have been accepted.
  task automatic run_session(input logic [6:0] nw, input int abort_after, input bit dense);
    int          cnt;
    int          nfull;
    int          nsend;
    int          i;
    int          stall;
    int          w0;
    bit          acc;
    logic [31:0] sum;
    logic [31:0] w;
    exp_t        e;

    cnt   = (nw == 0 || nw > 64) ? 64 : int'(nw);
    nfull = (abort_after < 0) ? cnt : abort_after / 4;
    nsend = (abort_after < 0) ? cnt * 4 : abort_after;
    while (bytes_q.size() < nsend) bytes_q.push_back(8'($urandom));

    sum = 32'd0;
    for (int k = 0; k < nfull; k++) begin
      w = {bytes_q[4*k+3], bytes_q[4*k+2], bytes_q[4*k+1], bytes_q[4*k]};
      e.is_done = 1'b0;
      e.wa = 32'(k * 4);
      e.wd = w;
      exp_q.push_back(e);
      sum = sum + w;
    end
    if (abort_after < 0) begin
      e.is_done = 1'b1;
      e.wa = 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      e.wd = sum;
`else
      e.wd = 32'd0;
`endif
      exp_q.push_back(e);
    end

    @(negedge clk);
    chk("hold_idle", 32'(cpu_hold), 32'd0);
    chk("ready_idle", 32'(byte_ready), 32'd0);
    w0 = writes_seen;
    start = 1'b1;
    num_words = nw;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("hold_recv", 32'(cpu_hold), 32'd1);

    i = 0;
    stall = 0;
    while (i < nsend) begin
      byte_valid = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
      byte_data  = bytes_q[i];
      // Stray start requests while busy must have no effect.
      start      = (!dense && byte_ready) ? ($urandom_range(0, 5) == 0) : 1'b0;
      num_words  = 7'($urandom);
      acc        = byte_valid && byte_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        i++;
        stall = 0;
      end else begin
        stall++;
        if (stall > 50) begin
          chk("byte_accept_timeout", 32'd1, 32'd0);
          break;
        end
      end
    end
    byte_valid = 1'b0;
    start = 1'b0;

    if (abort_after >= 0) begin
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      chk("abort_pending_exp", 32'(exp_q.size()), 32'd0);
      chk("abort_writes", 32'(writes_seen - w0), 32'(nfull));
      reset = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk("no_we_after_abort", 32'(we), 32'd0);
      end
    end else begin
      for (int c = 0; c < 20 && done !== 1'b1; c++) @(negedge clk);
      chk("done_seen", 32'(done), 32'd1);
      chk("session_writes", 32'(writes_seen - w0), 32'(cnt));
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("hold_released", 32'(cpu_hold), 32'd0);
    end
    bytes_q.delete();
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    num_words = 7'd0;
    byte_valid = 1'b0;
    byte_data = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;

    // Single word, back-to-back bytes.
    bytes_q = '{8'h13, 8'h05, 8'h50, 8'h00};
    run_session(7'd1, -1, 1'b1);

    // Two words with a known checksum.
    bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_session(7'd2, -1, 1'b1);

    // Zero and over-range counts both fill the whole memory.
    run_session(7'd0, -1, 1'b0);
    run_session(7'd100, -1, 1'b0);
    run_session(7'd64, -1, 1'b1);

    // Randomised sessions with gapped byte_valid and stray starts.
    for (int s = 0; s < 6; s++) begin
      run_session(7'($urandom_range(1, 20)), -1, 1'b0);
    end

    // Abort partway through the third word, then reload cleanly.
    run_session(7'd5, 10, 1'b0);
    run_session(7'd3, -1, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
